tm_sch_pri_rd_arb: RTL and testbench
====================================

// Module: tm_sch_pri_rd_arb
// PURPOSE
// - Round-robin arbiter that shares one fourth-level priority-scheduler control-memory read port among N_REQ scheduler engines.
// - Sits between the scheduler engines and one pio_mem_f application read port (app_mem_rd/raddr -> app_mem_ack/rdata).
// - Tracks outstanding reads with a tag FIFO and routes each returned entry (two packed queue IDs) to the requester that issued it.
// PARAMETERS
// - WIDTH        default (`FOURTH_LVL_QUEUE_ID_NBITS<<1)  control entry width.
// - DEPTH_NBITS  default `FOURTH_LVL_SCH_ID_NBITS         control-memory address width.
// - N_REQ        default 4                                number of requesters, 2..8.
// - MAX_OUTST    default 4                                max reads in flight, power of 2, >=2.
// PORTS
// - clk                 in   1                 sole clock.
// - rstn                in   1                 reset, asynchronous, active-low (`RESET_SIG).
// - req                 in   N_REQ             per-requester read request, held until granted.
// - req_raddr           in   N_REQ*DEPTH_NBITS packed addresses; slice i belongs to req[i].
// - gnt                 out  N_REQ             one-hot, 1-cycle pulse: request i accepted this cycle.
// - rsp_ack             out  N_REQ             one-hot, 1-cycle pulse: rsp_rdata is valid for requester i.
// - rsp_rdata           out  WIDTH             returned entry, shared by all requesters.
// - mem_rd              out  1                 read strobe to the pio_mem_f application port.
// - mem_raddr           out  DEPTH_NBITS       read address to the memory.
// - mem_ack             in   1                 memory read-data valid; acks return in issue order.
// - mem_rdata           in   WIDTH             memory read data.
// - outst_cnt           out  $clog2(MAX_OUTST)+1  reads currently in flight.
// - err_unexp_ack       out  1                 sticky: mem_ack arrived with no read in flight.
// BEHAVIOUR
// - Reset values: gnt=0, rsp_ack=0, rsp_rdata=0, mem_rd=0, mem_raddr=0, outst_cnt=0, err_unexp_ack=0, rr_ptr=0, tag FIFO empty.
// - Issue (cycle t):
//   - Issue is allowed when |req and (outst_cnt<MAX_OUTST or mem_ack at t).
//   - Winner = first set req bit at or after rr_ptr, scanning upward with wrap.
//   - gnt[winner] is asserted combinationally at t.
//   - mem_rd and mem_raddr are registered and driven at t+1.
//   - The winner ID is pushed to the tag FIFO at t.
//   - rr_ptr <= winner+1, modulo N_REQ; rr_ptr wraps N_REQ-1 -> 0.
//   - When no issue occurs, rr_ptr holds.
// - Requester rule: after gnt, a requester may drop req or present a new address in the next cycle; a held req re-competes.
// - Response:
//   - On mem_ack, pop the FIFO head tag.
//   - rsp_ack[tag] and rsp_rdata<=mem_rdata are registered: latency 1 cycle from mem_ack.
//   - Back-to-back acks give back-to-back rsp_ack pulses.
// - Counting:
//   - outst_cnt +1 on issue, -1 on mem_ack, unchanged when both occur in the same cycle.
//   - outst_cnt never exceeds MAX_OUTST.
// - Full: outst_cnt==MAX_OUTST with no mem_ack gives gnt=0; requests stall and are not dropped.
// - Unexpected ack: mem_ack with the FIFO empty and outst_cnt==0.
//   - No rsp_ack is asserted.
//   - err_unexp_ack sets and stays set until reset.
//   - The counter stays at 0.
// - Reset mid-operation: FIFO and counter clear immediately. Acks for pre-reset reads count as unexpected and set err_unexp_ack.
// - No FSM beyond the counter and pointer. The tag FIFO is the only storage: MAX_OUTST x $clog2(N_REQ) bits.
// STRUCTURE
// - tm_sch_pkg:
//   - typedef req_id_t, logic [$clog2(N_REQ)-1:0];
//   - function rr_pick(req, ptr), returning the one-hot winner.
// - Sub-module tm_sch_tag_fifo: synchronous FIFO, MAX_OUTST deep.
//   - Push and pop in the same cycle are allowed.
//   - Pop on empty is ignored.
//   - Combinational head output.
// - The top level holds arbitration, the counter, output registers and the error flag.
// TESTING
// - Single read: req=4'b0001 with addr 5 -> gnt[0] at t, mem_rd/addr 5 at t+1. mem_ack with data 0xA5 -> rsp_ack[0] with rdata 0xA5 one cycle later.
// - Fairness: req=4'b1111 held, mem_ack every cycle -> gnt order 0,1,2,3,0. Each requester gets 1/4 of grants.
// - Routing: issue from requesters 2,0,3, then three acks with data 1,2,3 -> rsp_ack[2]=1, rsp_ack[0]=2, rsp_ack[3]=3.
// - Full stall: MAX_OUTST=4, no acks -> 4 grants then gnt=0 with outst_cnt=4. An ack together with a pending req grants in the same cycle; outst_cnt stays 4.
// - Unexpected ack: mem_ack with outst_cnt=0 -> no rsp_ack, err_unexp_ack=1 and sticky.
// - Reset mid-flight: 2 outstanding, assert rstn=0 -> all outputs 0. Two post-reset acks -> err_unexp_ack=1, no rsp_ack.

Source files
------------

// File: rtl/tm_sch_pkg.sv
// Shared types and the round-robin pick helper for the fourth-level
// scheduler control-memory read arbiter.
package tm_sch_pkg;

    localparam int FOURTH_LVL_QUEUE_ID_NBITS = 8;
    localparam int FOURTH_LVL_SCH_ID_NBITS   = 6;
    localparam int TM_SCH_N_REQ              = 4;
    localparam int RR_MAX_REQ                = 8;

    typedef logic [$clog2(TM_SCH_N_REQ)-1:0] req_id_t;

    // One-hot winner: first set bit at or after ptr, wrapping at n_req.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [2:0]            ptr,
        input int                    n_req
    );
        logic [RR_MAX_REQ-1:0] pick;
        logic                  found;
        logic [2:0]            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % n_req);
            if (i < n_req && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tm_sch_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight memory read.
// Same-cycle push/pop allowed, pop on empty ignored, head is combinational.
module tm_sch_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
        head = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tm_sch_pri_rd_arb.sv
// Round-robin arbiter sharing one control-memory read port among N_REQ
// scheduler engines; returned entries are routed back by issue-order tag.
module tm_sch_pri_rd_arb
    import tm_sch_pkg::*;
#(
    parameter int WIDTH       = FOURTH_LVL_QUEUE_ID_NBITS << 1,
    parameter int DEPTH_NBITS = FOURTH_LVL_SCH_ID_NBITS,
    parameter int N_REQ       = TM_SCH_N_REQ,
    parameter int MAX_OUTST   = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DEPTH_NBITS-1:0] req_raddr,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rsp_ack,
    output logic [WIDTH-1:0]             rsp_rdata,
    output logic                         mem_rd,
    output logic [DEPTH_NBITS-1:0]       mem_raddr,
    input  logic                         mem_ack,
    input  logic [WIDTH-1:0]             mem_rdata,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         err_unexp_ack
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic [N_REQ-1:0]       rsp_ack_q, rsp_ack_d;
    logic [WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                   mem_rd_q, mem_rd_d;
    logic [DEPTH_NBITS-1:0] mem_raddr_q, mem_raddr_d;
    logic [CNT_W-1:0]       outst_cnt_q, outst_cnt_d;
    logic                   err_q, err_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [RR_MAX_REQ-1:0]  req_pad;
    logic [2:0]             ptr_pad;
    logic [RR_MAX_REQ-1:0]  pick;
    logic                   pick_unused;
    logic [N_REQ-1:0]       gnt_vec;
    logic [ID_W-1:0]        win_id;
    logic [DEPTH_NBITS-1:0] win_addr;
    logic                   issue;
    logic                   ack_valid;
    logic [ID_W-1:0]        fifo_head;
    logic                   fifo_empty;

    always_comb begin
        req_pad                = '0;
        req_pad[N_REQ-1:0]     = req;
        ptr_pad                = '0;
        ptr_pad[ID_W-1:0]      = rr_ptr_q;
        pick                   = rr_pick(req_pad, ptr_pad, N_REQ);
    end

    assign pick_unused = ^pick;

    always_comb begin
        // An ack frees a slot in the same cycle, so a full arbiter can still issue.
        ack_valid = mem_ack && !fifo_empty;
        issue     = (|req) && ((outst_cnt_q != MAX_CNT) || ack_valid);
        gnt_vec   = issue ? pick[N_REQ-1:0] : '0;
        win_id    = '0;
        win_addr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                win_id   = ID_W'(i);
                win_addr = req_raddr[i*DEPTH_NBITS +: DEPTH_NBITS];
            end
        end
    end

    always_comb begin
        mem_rd_d    = issue;
        mem_raddr_d = issue ? win_addr : mem_raddr_q;
        rr_ptr_d    = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
        end
        outst_cnt_d = outst_cnt_q;
        if (issue && !ack_valid) begin
            outst_cnt_d = outst_cnt_q + CNT_W'(1);
        end else if (!issue && ack_valid) begin
            outst_cnt_d = outst_cnt_q - CNT_W'(1);
        end
        for (int i = 0; i < N_REQ; i++) begin
            rsp_ack_d[i] = ack_valid && (fifo_head == ID_W'(i));
        end
        rsp_rdata_d = ack_valid ? mem_rdata : rsp_rdata_q;
        err_d       = err_q || (mem_ack && fifo_empty);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_raddr_q <= '0;
            outst_cnt_q <= '0;
            err_q       <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_ack_q   <= rsp_ack_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_raddr_q <= mem_raddr_d;
            outst_cnt_q <= outst_cnt_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    tm_sch_tag_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (issue),
        .din   (win_id),
        .pop   (ack_valid),
        .head  (fifo_head),
        .empty (fifo_empty)
    );

    assign gnt           = gnt_vec;
    assign rsp_ack       = rsp_ack_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign mem_rd        = mem_rd_q;
    assign mem_raddr     = mem_raddr_q;
    assign outst_cnt     = outst_cnt_q;
    assign err_unexp_ack = err_q;

endmodule

// File: tb/tb_tm_sch_pri_rd_arb.sv
// Self-checking bench for tm_sch_pri_rd_arb: directed scenarios plus a
// random run, with returned entries checked against an expected queue.
module tb_tm_sch_pri_rd_arb;

    localparam int W  = 16;
    localparam int DW = 6;
    localparam int NR = 4;
    localparam int MO = 4;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] req_raddr = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rsp_ack;
    logic [W-1:0]     rsp_rdata;
    logic             mem_rd;
    logic [DW-1:0]    mem_raddr;
    logic             mem_ack = 1'b0;
    logic [W-1:0]     mem_rdata = '0;
    logic [CW-1:0]    outst_cnt;
    logic             err_unexp_ack;

    int total = 0;
    int bad   = 0;

    logic [W+1:0] exp_q[$];
    logic [1:0]   tag_q[$];
    logic [W+1:0] mon_e;
    logic [NR-1:0] mon_ack;

    always #5 clk = ~clk;

    tm_sch_pri_rd_arb #(
        .WIDTH       (W),
        .DEPTH_NBITS (DW),
        .N_REQ       (NR),
        .MAX_OUTST   (MO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .req_raddr     (req_raddr),
        .gnt           (gnt),
        .rsp_ack       (rsp_ack),
        .rsp_rdata     (rsp_rdata),
        .mem_rd        (mem_rd),
        .mem_raddr     (mem_raddr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .outst_cnt     (outst_cnt),
        .err_unexp_ack (err_unexp_ack)
    );

    // Every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rsp_ack !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: rsp_ack=%b rdata=%h, expected no response", rsp_ack, rsp_rdata);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_ack = 4'b0001 << mon_e[W+1:W];
                if (rsp_ack !== mon_ack || rsp_rdata !== mon_e[W-1:0]) begin
                    bad++;
                    $display("FAIL rsp_route: rsp_ack=%b rdata=%h, expected %b %h", rsp_ack, rsp_rdata, mon_ack, mon_e[W-1:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ack(input logic [W-1:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        if (tag_q.size() > 0) exp_q.push_back({tag_q.pop_front(), data});
    endtask

    task automatic set_addr(input int id, input logic [DW-1:0] a);
        req_raddr[id*DW +: DW] = a;
    endtask

    task automatic do_reset();
        req     = '0;
        mem_ack = 1'b0;
        rstn    = 1'b0;
        tag_q.delete();
        exp_q.delete();
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        next_cycle();
    endtask

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        req  = '0;
        #2;
        total++; if (gnt !== '0)          begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        total++; if (rsp_ack !== '0)      begin bad++; $display("FAIL reset_rsp_ack: got %b want 0", rsp_ack); end
        total++; if (rsp_rdata !== '0)    begin bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        total++; if (mem_rd !== 1'b0)     begin bad++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        total++; if (mem_raddr !== '0)    begin bad++; $display("FAIL reset_mem_raddr: got %h want 0", mem_raddr); end
        total++; if (outst_cnt !== '0)    begin bad++; $display("FAIL reset_outst: got %0d want 0", outst_cnt); end
        total++; if (err_unexp_ack !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_unexp_ack); end
        do_reset();
    endtask

    task automatic test_single();
        set_addr(0, 6'd5);
        req = 4'b0001;
        tag_q.push_back(2'd0);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        next_cycle();
        req = '0;
        @(negedge clk);
        total++; if (mem_rd !== 1'b1)   begin bad++; $display("FAIL single_mem_rd: got %b want 1", mem_rd); end
        total++; if (mem_raddr !== 6'd5) begin bad++; $display("FAIL single_mem_raddr: got %0d want 5", mem_raddr); end
        total++; if (outst_cnt !== 3'd1) begin bad++; $display("FAIL single_outst: got %0d want 1", outst_cnt); end
        next_cycle();
        @(negedge clk);
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL single_mem_rd_pulse: got %b want 0", mem_rd); end
        next_cycle();
        drive_ack(16'h00A5);
        @(negedge clk);
        total++; if (rsp_ack !== '0) begin bad++; $display("FAIL single_rsp_early: got %b want 0", rsp_ack); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (rsp_ack !== 4'b0001)   begin bad++; $display("FAIL single_rsp_ack: got %b want 0001", rsp_ack); end
        total++; if (rsp_rdata !== 16'h00A5) begin bad++; $display("FAIL single_rsp_rdata: got %h want 00a5", rsp_rdata); end
        total++; if (outst_cnt !== 3'd0)    begin bad++; $display("FAIL single_outst_done: got %0d want 0", outst_cnt); end
        next_cycle();
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) drive_ack(16'h0100 + 16'(c));
            tag_q.push_back(2'(c % NR));
            @(negedge clk);
            total++;
            if (gnt !== (4'b0001 << (c % NR))) begin
                bad++; $display("FAIL fair_gnt%0d: got %b want %b", c, gnt, 4'b0001 << (c % NR));
            end
            if (c > 0) begin
                total++; if (outst_cnt !== 3'd1) begin bad++; $display("FAIL fair_outst%0d: got %0d want 1", c, outst_cnt); end
            end
            next_cycle();
            mem_ack = 1'b0;
        end
        req = '0;
        drive_ack(16'h0200);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (outst_cnt !== 3'd0) begin bad++; $display("FAIL fair_drain: got %0d want 0", outst_cnt); end
        next_cycle();
    endtask

    task automatic test_routing();
        logic [1:0]    ids   [3];
        logic [DW-1:0] addrs [3];
        logic [NR-1:0] acks  [3];
        ids   = '{2'd2, 2'd0, 2'd3};
        addrs = '{6'd7, 6'd9, 6'd63};
        acks  = '{4'b0100, 4'b0001, 4'b1000};
        for (int k = 0; k < 3; k++) begin
            set_addr(int'(ids[k]), addrs[k]);
            req = 4'b0001 << ids[k];
            tag_q.push_back(ids[k]);
            @(negedge clk);
            total++; if (gnt !== acks[k]) begin bad++; $display("FAIL route_gnt%0d: got %b want %b", k, gnt, acks[k]); end
            next_cycle();
            req = '0;
            @(negedge clk);
            total++; if (mem_raddr !== addrs[k]) begin bad++; $display("FAIL route_addr%0d: got %0d want %0d", k, mem_raddr, addrs[k]); end
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive_ack(16'(k + 1));
            else mem_ack = 1'b0;
            @(negedge clk);
            if (k > 0) begin
                total++;
                if (rsp_ack !== acks[k-1] || rsp_rdata !== 16'(k)) begin
                    bad++; $display("FAIL route_rsp%0d: got %b/%h want %b/%h", k, rsp_ack, rsp_rdata, acks[k-1], 16'(k));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tag_q.push_back(2'(c));
            @(negedge clk);
            total++; if (gnt !== (4'b0001 << c)) begin bad++; $display("FAIL full_gnt%0d: got %b want %b", c, gnt, 4'b0001 << c); end
            next_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (gnt !== '0)        begin bad++; $display("FAIL full_stall_gnt%0d: got %b want 0", c, gnt); end
            total++; if (outst_cnt !== 3'd4) begin bad++; $display("FAIL full_stall_cnt%0d: got %0d want 4", c, outst_cnt); end
            next_cycle();
        end
        drive_ack(16'h0300);
        tag_q.push_back(2'd0);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL full_ack_gnt: got %b want 0001", gnt); end
        next_cycle();
        req     = '0;
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (outst_cnt !== 3'd4) begin bad++; $display("FAIL full_ack_cnt: got %0d want 4", outst_cnt); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_ack(16'h0310 + 16'(k));
        end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (outst_cnt !== 3'd0) begin bad++; $display("FAIL full_drain: got %0d want 0", outst_cnt); end
        next_cycle();
    endtask

    task automatic test_unexp_ack();
        drive_ack(16'hDEAD);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (rsp_ack !== '0)         begin bad++; $display("FAIL unexp_rsp: got %b want 0", rsp_ack); end
        total++; if (err_unexp_ack !== 1'b1) begin bad++; $display("FAIL unexp_err: got %b want 1", err_unexp_ack); end
        total++; if (outst_cnt !== 3'd0)     begin bad++; $display("FAIL unexp_cnt: got %0d want 0", outst_cnt); end
        repeat (3) next_cycle();
        @(negedge clk);
        total++; if (err_unexp_ack !== 1'b1) begin bad++; $display("FAIL unexp_sticky: got %b want 1", err_unexp_ack); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        total++; if (err_unexp_ack !== 1'b0) begin bad++; $display("FAIL mid_err_clear: got %b want 0", err_unexp_ack); end
        set_addr(0, 6'd11);
        set_addr(1, 6'd22);
        req = 4'b0001;
        tag_q.push_back(2'd0);
        next_cycle();
        req = 4'b0010;
        tag_q.push_back(2'd1);
        next_cycle();
        req = '0;
        @(negedge clk);
        total++; if (outst_cnt !== 3'd2) begin bad++; $display("FAIL mid_cnt: got %0d want 2", outst_cnt); end
        next_cycle();
        rstn = 1'b0;
        tag_q.delete();
        #1;
        total++; if (outst_cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", outst_cnt); end
        total++; if (mem_raddr !== '0 || mem_rd !== 1'b0) begin bad++; $display("FAIL mid_rst_mem: got %b/%0d want 0/0", mem_rd, mem_raddr); end
        total++; if (rsp_ack !== '0 || rsp_rdata !== '0 || gnt !== '0) begin bad++; $display("FAIL mid_rst_rsp: got %b/%h/%b want 0", rsp_ack, rsp_rdata, gnt); end
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive_ack(16'h0400 + 16'(k));
            next_cycle();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (rsp_ack !== '0)         begin bad++; $display("FAIL mid_post_rsp: got %b want 0", rsp_ack); end
        total++; if (err_unexp_ack !== 1'b1) begin bad++; $display("FAIL mid_post_err: got %b want 1", err_unexp_ack); end
        total++; if (outst_cnt !== 3'd0)     begin bad++; $display("FAIL mid_post_cnt: got %0d want 0", outst_cnt); end
        next_cycle();
    endtask

    task automatic test_random();
        int            ptr;
        int            cnt;
        int            win;
        logic          ack;
        logic          can;
        logic [3:0]    r;
        logic [NR-1:0] exp_g;
        logic          prev_issue;
        logic [DW-1:0] prev_addr;
        do_reset();
        ptr = 0;
        cnt = 0;
        prev_issue = 1'b0;
        prev_addr  = '0;
        for (int c = 0; c < 300; c++) begin
            r = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) set_addr(i, DW'($urandom_range(0, 63)));
            ack = (cnt > 0) && ($urandom_range(0, 1) == 1);
            req = r;
            if (ack) drive_ack(16'($urandom_range(0, 65535)));
            else mem_ack = 1'b0;
            can   = (cnt < MO) || ack;
            win   = (r != 0 && can) ? model_pick(r, ptr) : -1;
            exp_g = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            @(negedge clk);
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rand_gnt%0d: got %b want %b", c, gnt, exp_g); end
            total++; if (outst_cnt !== CW'(cnt)) begin bad++; $display("FAIL rand_cnt%0d: got %0d want %0d", c, outst_cnt, cnt); end
            total++;
            if (mem_rd !== prev_issue || (prev_issue && mem_raddr !== prev_addr)) begin
                bad++; $display("FAIL rand_mem%0d: got %b/%0d want %b/%0d", c, mem_rd, mem_raddr, prev_issue, prev_addr);
            end
            prev_issue = (win >= 0);
            if (win >= 0) begin
                prev_addr = req_raddr[win*DW +: DW];
                tag_q.push_back(2'(win));
                ptr = (win + 1) % NR;
            end
            cnt = cnt + ((win >= 0) ? 1 : 0) - (ack ? 1 : 0);
            next_cycle();
        end
        req = '0;
        for (int k = 0; k < MO + 2; k++) begin
            if (cnt > 0) begin
                drive_ack(16'h0500 + 16'(k));
                cnt--;
            end else begin
                mem_ack = 1'b0;
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (outst_cnt !== 3'd0)     begin bad++; $display("FAIL rand_drain: got %0d want 0", outst_cnt); end
        total++; if (err_unexp_ack !== 1'b0) begin bad++; $display("FAIL rand_err: got %b want 0", err_unexp_ack); end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_routing();
        test_full_stall();
        test_unexp_ack();
        test_reset_midflight();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing: %0d responses never seen, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
